wei_expand: RTL

- Sits directly downstream of the weight-distribution FIFO, between it and the PEC MAC array.
- Pops one compressed block per fetch: nine packed nonzero-weight rows plus their 288-bit sparsity flags.
- Scatters each kernel position's packed nonzeros back into a dense BLOCK_DEPTH-lane row.
- Emits the nine dense rows one per handshake (kernel position 0..8) on a valid/ready interface.

---
 rtl/wei_pkg.sv | 21 ++
 rtl/wei_expand_if.sv | 28 ++
 rtl/wei_row_scatter.sv | 36 +++
 rtl/wei_expand.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/wei_pkg.sv
// Shared parameters, derived widths and FSM encoding for the weight expander.
package wei_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int BLOCK_DEPTH = 32;
  localparam int KERNEL_SIZE = 9;

  localparam int ROW_W   = DATA_WIDTH * BLOCK_DEPTH;  // one dense or packed row
  localparam int BLOCK_W = ROW_W * KERNEL_SIZE;       // one compressed block
  localparam int FLAG_W  = BLOCK_DEPTH * KERNEL_SIZE; // flags of one block
  localparam int IDX_W   = 4;                         // kernel position index
  localparam int CNT_W   = 6;                         // prefix popcount width

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_SIZE - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } wei_state_e;

endpackage

// File: rtl/wei_expand_if.sv
// Bundle of the upstream FIFO head and the downstream PEC row handshake.
// master = the surrounding environment, slave = the expander itself.
interface wei_expand_if;
  import wei_pkg::*;

  logic                   CTRLACT_FnhFrm;
  logic                   DISWEI_RdyFIFO;
  logic                   CTRLWEI_PlsFetch;
  logic [BLOCK_W-1:0]     DISWEIPEC_Wei;
  logic [FLAG_W-1:0]      DISWEIPEC_FlgWei;
  logic                   WEIPEC_Val;
  logic                   WEIPEC_Rdy;
  logic [ROW_W-1:0]       WEIPEC_Wei;
  logic [BLOCK_DEPTH-1:0] WEIPEC_FlgRow;
  logic [IDX_W-1:0]       WEIPEC_IdxKer;
  logic                   WEIPEC_Last;

  modport master (
    output CTRLACT_FnhFrm, DISWEI_RdyFIFO, DISWEIPEC_Wei, DISWEIPEC_FlgWei, WEIPEC_Rdy,
    input  CTRLWEI_PlsFetch, WEIPEC_Val, WEIPEC_Wei, WEIPEC_FlgRow, WEIPEC_IdxKer, WEIPEC_Last
  );

  modport slave (
    input  CTRLACT_FnhFrm, DISWEI_RdyFIFO, DISWEIPEC_Wei, DISWEIPEC_FlgWei, WEIPEC_Rdy,
    output CTRLWEI_PlsFetch, WEIPEC_Val, WEIPEC_Wei, WEIPEC_FlgRow, WEIPEC_IdxKer, WEIPEC_Last
  );

endinterface

// File: rtl/wei_row_scatter.sv
// Combinational scatter of one packed nonzero row back into a dense row.
// Lane l takes packed byte popcount(flg[l-1:0]) when its flag is set.
module wei_row_scatter
  import wei_pkg::*;
(
  input  logic [ROW_W-1:0]       pk_row_i,
  input  logic [BLOCK_DEPTH-1:0] flg_i,
  output logic [ROW_W-1:0]       dense_o
);

  logic [DATA_WIDTH-1:0] pk_byte_s [BLOCK_DEPTH];
  logic [CNT_W-1:0]      cnt_s;

  // Split the packed row into addressable bytes.
  always_comb begin
    for (int j = 0; j < BLOCK_DEPTH; j++) begin
      pk_byte_s[j] = pk_row_i[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Running prefix count selects the packed byte for each flagged lane.
  always_comb begin
    cnt_s   = {CNT_W{1'b0}};
    dense_o = {ROW_W{1'b0}};
    for (int l = 0; l < BLOCK_DEPTH; l++) begin
      if (flg_i[l]) begin
        // prefix count is at most 31 here, so the low bits index all bytes
        dense_o[l*DATA_WIDTH +: DATA_WIDTH] = pk_byte_s[cnt_s[CNT_W-2:0]];
      end else begin
        dense_o[l*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
      cnt_s = cnt_s + {{(CNT_W-1){1'b0}}, flg_i[l]};
    end
  end

endmodule

// File: rtl/wei_expand.sv
// Weight expander: pops compressed blocks from the weight FIFO and emits the
// nine dense kernel-position rows to the PEC, one per valid/ready handshake.
module wei_expand
  import wei_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  wei_expand_if.slave bus
);

  wei_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   val_q;
  logic                   last_q;
  logic [ROW_W-1:0]       row_q;
  logic [BLOCK_DEPTH-1:0] flg_q;
  logic [BLOCK_W-1:0]     blk_wei_q;
  logic [FLAG_W-1:0]      blk_flg_q;

  logic                   hs_s;
  logic                   fetch_s;
  logic [BLOCK_W-1:0]     src_wei_s;
  logic [FLAG_W-1:0]      src_flg_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic [ROW_W-1:0]       ker_row_s [KERNEL_SIZE];
  logic [BLOCK_DEPTH-1:0] ker_flg_s [KERNEL_SIZE];
  logic [ROW_W-1:0]       pk_row_s;
  logic [BLOCK_DEPTH-1:0] pk_flg_s;
  logic [ROW_W-1:0]       dense_s;

  // Pop decision: the FIFO is fall-through, so the pop must be decided in the
  // same cycle the block is captured; it cannot be a registered pulse.
  always_comb begin
    hs_s = val_q && bus.WEIPEC_Rdy;
    if (rst || bus.CTRLACT_FnhFrm) begin
      fetch_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: fetch_s = bus.DISWEI_RdyFIFO;
        ST_EMIT: fetch_s = bus.DISWEI_RdyFIFO && hs_s && (idx_q == LAST_IDX);
        default: fetch_s = 1'b0;
      endcase
    end
  end

  // Source of the next row: row 0 straight from the FIFO head when fetching,
  // otherwise the following kernel position of the latched block.
  always_comb begin
    if (fetch_s) begin
      src_wei_s = bus.DISWEIPEC_Wei;
      src_flg_s = bus.DISWEIPEC_FlgWei;
      sel_idx_s = {IDX_W{1'b0}};
    end else begin
      src_wei_s = blk_wei_q;
      src_flg_s = blk_flg_q;
      sel_idx_s = idx_q + 4'd1;
    end
  end

  // Kernel position k lives at the high end of the block (position 0 is MSB).
  always_comb begin
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      ker_row_s[k] = src_wei_s[(KERNEL_SIZE-1-k)*ROW_W +: ROW_W];
      ker_flg_s[k] = src_flg_s[(KERNEL_SIZE-1-k)*BLOCK_DEPTH +: BLOCK_DEPTH];
    end
  end

  // Kernel-position mux feeding the single scatter instance.
  always_comb begin
    if (sel_idx_s <= LAST_IDX) begin
      pk_row_s = ker_row_s[sel_idx_s];
      pk_flg_s = ker_flg_s[sel_idx_s];
    end else begin
      pk_row_s = {ROW_W{1'b0}};
      pk_flg_s = {BLOCK_DEPTH{1'b0}};
    end
  end

  wei_row_scatter u_scatter (
    .pk_row_i (pk_row_s),
    .flg_i    (pk_flg_s),
    .dense_o  (dense_s)
  );

  // Control FSM with registered row outputs; flush and reset clear everything.
  always_ff @(posedge clk) begin
    if (rst || bus.CTRLACT_FnhFrm) begin
      state_q   <= ST_IDLE;
      idx_q     <= {IDX_W{1'b0}};
      val_q     <= 1'b0;
      last_q    <= 1'b0;
      row_q     <= {ROW_W{1'b0}};
      flg_q     <= {BLOCK_DEPTH{1'b0}};
      blk_wei_q <= {BLOCK_W{1'b0}};
      blk_flg_q <= {FLAG_W{1'b0}};
    end else if (fetch_s) begin
      state_q   <= ST_EMIT;
      blk_wei_q <= bus.DISWEIPEC_Wei;
      blk_flg_q <= bus.DISWEIPEC_FlgWei;
      idx_q     <= {IDX_W{1'b0}};
      val_q     <= 1'b1;
      last_q    <= 1'b0;
      row_q     <= dense_s;
      flg_q     <= pk_flg_s;
    end else begin
      case (state_q)
        ST_IDLE: begin
          val_q  <= 1'b0;
          last_q <= 1'b0;
        end
        ST_EMIT: begin
          if (hs_s) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              idx_q   <= {IDX_W{1'b0}};
              val_q   <= 1'b0;
              last_q  <= 1'b0;
              row_q   <= {ROW_W{1'b0}};
              flg_q   <= {BLOCK_DEPTH{1'b0}};
            end else begin
              idx_q  <= sel_idx_s;
              row_q  <= dense_s;
              flg_q  <= pk_flg_s;
              last_q <= (sel_idx_s == LAST_IDX);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= {IDX_W{1'b0}};
          val_q   <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CTRLWEI_PlsFetch = fetch_s;
  assign bus.WEIPEC_Val       = val_q;
  assign bus.WEIPEC_Wei       = row_q;
  assign bus.WEIPEC_FlgRow    = flg_q;
  assign bus.WEIPEC_IdxKer    = idx_q;
  assign bus.WEIPEC_Last      = last_q;

endmodule
